digit_scanner: RTL and testbench
================================

# digit_scanner

Time-multiplexed seven-segment display driver for the stopwatch display path. The upstream select logic merges several digit sources into one set of BCD values; this block fans them back out in time. It drives one shared segment bus and walks a one-hot anode strobe across `NUM_DIGITS` digits. Each digit gets a fixed dwell period, preceded by a blanking guard that suppresses ghosting.

## Interface
- `NUM_DIGITS`, 4: digits scanned (2..8).
- `REFRESH_DIV`, 50000: clock cycles each digit is driven (≥2).
- `BLANK_CYCLES`, 500: guard cycles, anodes all off, before each digit (≥1).
- `clock`  in  1  system clock, rising-edge.
- `reset`  in  1  synchronous, active-high reset; one clock and this reset drive all state.
- `enable`  in  1  scan enable; low forces display dark.
- `digits`  in  4*NUM_DIGITS  BCD digits; `[3:0]` is digit 0 (least significant, rightmost).
- `dp_mask`  in  NUM_DIGITS  decimal point request per digit, active-high.
- `blank_lz`  in  1  leading-zero blanking enable.
- `seg`  out  7  `{g,f,e,d,c,b,a}`, active-low.
- `dp`  out  1  decimal point, active-low.
- `anode`  out  NUM_DIGITS  digit strobe, active-low, at most one bit low.
- `digit_tick`  out  1  one-cycle pulse at the end of each digit's dwell.

## Operation
- States: OFF, GUARD, DRIVE. State is held in a 2-bit register.
- Supporting registers:
  - dwell counter `cnt`, wide enough for max(`REFRESH_DIV`, `BLANK_CYCLES`);
  - digit index `idx` (0..`NUM_DIGITS`-1);
  - snapshot register `snap` (copy of `digits`) and `dp_snap` (copy of `dp_mask`).
- OFF: all outputs dark. When `enable`=1, the next state is GUARD with `idx`=0 and `cnt`=0, and `digits`/`dp_mask` are captured into the snapshot.
- GUARD: anodes all high, `seg`=7'h7F, `dp`=1. After `BLANK_CYCLES` cycles, go to DRIVE with `cnt`=0.
- DRIVE: `anode[idx]`=0, `seg`=decode(`snap[idx]`), `dp`=~`dp_snap[idx]`. After `REFRESH_DIV` cycles:
  - pulse `digit_tick`;
  - set `idx` to `idx`+1, wrapping `NUM_DIGITS`-1 → 0;
  - go to GUARD.
  - On the wrap to 0, re-capture the snapshot. Inputs are sampled only at frame start, so no frame tears.
- Decode (active-low), values 0..9:
  - 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19
  - 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10
- Decode of illegal BCD values 10..15: dash, 7'h3F.
- Leading-zero blanking, when `blank_lz`=1:
  - Digit k>0 is blanked (`seg`=7'h7F) if `snap[k]` and every more-significant snapshot digit equal 0.
  - Digit 0 is never blanked.
  - `dp` is unaffected by blanking.
  - The anode still strobes during a blanked digit, so scan timing is constant.
- `blank_lz` is sampled live, not snapshotted.
- `enable` falling in any state: next state is OFF, and `idx`/`cnt` are cleared. No `digit_tick` is emitted for a truncated dwell.

## Timing
- All outputs are registered and update on the same edge as the state they reflect.
- Reset values: state OFF, `anode` all 1, `seg`=7'h7F, `dp`=1, `digit_tick`=0, `idx`=0, `cnt`=0, snapshot 0.
- Reset has priority over `enable`. Reset mid-DRIVE yields dark outputs on the next edge.
- Latency from `enable` rising: first anode goes low after 1 + `BLANK_CYCLES` cycles.
- Frame period is `NUM_DIGITS`×(`BLANK_CYCLES`+`REFRESH_DIV`) cycles.
- Each anode is low for exactly `REFRESH_DIV` consecutive cycles.
- `digit_tick` is high in the last DRIVE cycle only.
- Anode transitions are always separated by ≥`BLANK_CYCLES` all-high cycles. Two anodes are never low simultaneously, including across wrap and enable toggles.
- Input changes mid-frame do not appear until the next frame starts.

## Test plan
Bench parameters: `NUM_DIGITS`=4, `REFRESH_DIV`=4, `BLANK_CYCLES`=1 (frame = 20 cycles).
- Reset then `enable`=1, `digits`=16'h1234 → after 2 cycles `anode`=4'b1110 with `seg`=7'h19 for 4 cycles. Then 1 dark cycle, then `anode`=4'b1101 with `seg`=7'h30. Sequence repeats every 20 cycles, one `digit_tick` per digit.
- `digits`=16'h0050, `blank_lz`=1 → digits 3 and 2 show 7'h7F. Digit 1 shows 7'h12, digit 0 shows 7'h40. With `blank_lz`=0, digits 3 and 2 show 7'h40.
- `digits`=16'h00A0, `dp_mask`=4'b0100 → digit 1 shows 7'h3F. Digit 2 shows `dp`=0 and, because `blank_lz`=0, `seg`=7'h40.
- Change `digits` from 16'h1111 to 16'h2222 during digit 1's dwell → digits 2 and 3 still show 7'h79. 7'h24 appears only from the next digit 0.
- Drop `enable` mid-DRIVE of digit 2 → next cycle `anode`=4'hF, `seg`=7'h7F, no `digit_tick`. Re-enable → scan restarts at digit 0 after 2 cycles.
- Assert `reset` for 1 cycle mid-frame with `enable`=1 held → outputs at reset values on the next edge. Scan restarts at digit 0.
- Every scenario continuously checks the one-hot-or-none anode invariant.

Source files
------------

// File: rtl/digit_scanner.sv
// Time-multiplexed seven-segment scanner: one shared active-low segment bus, a walking
// active-low anode strobe, and a blanking guard before every digit's dwell.
module digit_scanner #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic                    blank_lz,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic                    digit_tick
);

    localparam int MAXV = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CW   = $clog2(MAXV);
    localparam int IW   = $clog2(NUM_DIGITS);

    localparam logic [CW-1:0] R_LAST   = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] R_PRE    = CW'(REFRESH_DIV - 2);
    localparam logic [CW-1:0] B_LAST   = CW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {OFF, GUARD, DRIVE} state_t;

    state_t                  state;
    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] snap;
    logic [NUM_DIGITS-1:0]   dp_snap;

    logic [3:0]              cur_digit;
    logic                    nonzero_above;
    logic [6:0]              drive_seg;
    logic                    drive_dp;
    logic [NUM_DIGITS-1:0]   drive_anode;

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'd0:    decode = 7'h40;
            4'd1:    decode = 7'h79;
            4'd2:    decode = 7'h24;
            4'd3:    decode = 7'h30;
            4'd4:    decode = 7'h19;
            4'd5:    decode = 7'h12;
            4'd6:    decode = 7'h02;
            4'd7:    decode = 7'h78;
            4'd8:    decode = 7'h00;
            4'd9:    decode = 7'h10;
            default: decode = 7'h3F;
        endcase
    endfunction

    // Leading-zero test looks at the current digit and everything more significant.
    always_comb begin
        cur_digit     = '0;
        nonzero_above = 1'b0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (IW'(k) == idx)
                cur_digit = snap[4*k +: 4];
            if (IW'(k) >= idx && snap[4*k +: 4] != 4'd0)
                nonzero_above = 1'b1;
        end
        if (blank_lz && idx != '0 && !nonzero_above)
            drive_seg = 7'h7F;
        else
            drive_seg = decode(cur_digit);
        drive_dp    = ~dp_snap[idx];
        drive_anode = ~(NUM_DIGITS'(1) << idx);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= OFF;
            cnt        <= '0;
            idx        <= '0;
            snap       <= '0;
            dp_snap    <= '0;
            anode      <= '1;
            seg        <= '1;
            dp         <= 1'b1;
            digit_tick <= 1'b0;
        end else if (!enable) begin
            state      <= OFF;
            cnt        <= '0;
            idx        <= '0;
            anode      <= '1;
            seg        <= '1;
            dp         <= 1'b1;
            digit_tick <= 1'b0;
        end else begin
            anode      <= '1;
            seg        <= '1;
            dp         <= 1'b1;
            digit_tick <= 1'b0;
            case (state)
                OFF: begin
                    state   <= GUARD;
                    cnt     <= '0;
                    idx     <= '0;
                    snap    <= digits;
                    dp_snap <= dp_mask;
                end
                GUARD: begin
                    if (cnt == B_LAST) begin
                        state <= DRIVE;
                        cnt   <= '0;
                        anode <= drive_anode;
                        seg   <= drive_seg;
                        dp    <= drive_dp;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DRIVE: begin
                    if (cnt == R_LAST) begin
                        state <= GUARD;
                        cnt   <= '0;
                        if (idx == IDX_LAST) begin
                            idx     <= '0;
                            snap    <= digits;
                            dp_snap <= dp_mask;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        // Tick is registered one cycle early so it lands on the last dwell cycle.
                        cnt        <= cnt + 1'b1;
                        anode      <= drive_anode;
                        seg        <= drive_seg;
                        dp         <= drive_dp;
                        digit_tick <= (cnt == R_PRE);
                    end
                end
                default: begin
                    state <= OFF;
                    cnt   <= '0;
                    idx   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_digit_scanner.sv
// Bench for digit_scanner: a time-since-scan-start model predicts every output each cycle
// under directed scenarios and randomized digits, enable drops and reset pulses.
module tb_digit_scanner;

    localparam int N  = 4;
    localparam int R  = 4;
    localparam int B  = 1;
    localparam int SL = B + R;
    localparam int F  = N * SL;

    logic            clock = 1'b0;
    logic            reset;
    logic            enable;
    logic [4*N-1:0]  digits;
    logic [N-1:0]    dp_mask;
    logic            blank_lz;
    logic [6:0]      seg;
    logic            dp;
    logic [N-1:0]    anode;
    logic            digit_tick;

    int checks = 0;
    int errors = 0;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

    bit         running = 1'b0;
    int         tm = 0;
    logic [15:0] msnap = '0;
    logic [3:0]  mdp = '0;

    digit_scanner #(
        .NUM_DIGITS  (N),
        .REFRESH_DIV (R),
        .BLANK_CYCLES(B)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .digits    (digits),
        .dp_mask   (dp_mask),
        .blank_lz  (blank_lz),
        .seg       (seg),
        .dp        (dp),
        .anode     (anode),
        .digit_tick(digit_tick)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp_v);
        end
    endtask

    // One clock: model advances with the inputs the DUT sees at this edge, then outputs are compared.
    task automatic step();
        logic        r, e, blz;
        logic [15:0] d;
        logic [3:0]  m;
        logic [3:0]  ea;
        logic [6:0]  es;
        logic        ed, et;
        int          pos, dg, w, zc;
        r = reset; e = enable; blz = blank_lz; d = digits; m = dp_mask;
        @(posedge clock);
        if (r || !e) begin
            running = 1'b0;
        end else if (!running) begin
            running = 1'b1;
            tm = 0;
            msnap = d;
            mdp = m;
        end else begin
            tm++;
            if (tm % F == 0) begin
                msnap = d;
                mdp = m;
            end
        end
        #1;
        ea = 4'hF; es = 7'h7F; ed = 1'b1; et = 1'b0;
        if (running) begin
            pos = tm % F;
            dg  = pos / SL;
            w   = pos % SL;
            if (w >= B) begin
                ea = 4'hF;
                ea[dg] = 1'b0;
                if (blz && dg > 0 && (msnap >> (4 * dg)) == 16'd0)
                    es = 7'h7F;
                else
                    es = seg_tab[(msnap >> (4 * dg)) & 16'hF];
                ed = ~mdp[dg];
                et = (w == SL - 1);
            end
        end
        zc = 0;
        for (int i = 0; i < N; i++) if (anode[i] === 1'b0) zc++;
        check("anode", 32'(anode), 32'(ea));
        check("seg", 32'(seg), 32'(es));
        check("dp", 32'(dp), 32'(ed));
        check("digit_tick", 32'(digit_tick), 32'(et));
        check("anode_onehot", 32'(zc <= 1), 32'd1);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic restart(input logic [15:0] d, input logic [3:0] m, input logic blz);
        enable = 1'b0;
        step();
        digits = d; dp_mask = m; blank_lz = blz;
        enable = 1'b1;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; digits = '0; dp_mask = '0; blank_lz = 1'b0;
        run(2);
        reset = 1'b0;
        run(2);

        // Basic scan, explicit first-digit latency checks then model-checked frames
        digits = 16'h1234; enable = 1'b1;
        run(2);
        check("first_anode", 32'(anode), 32'h0000000E);
        check("first_seg", 32'(seg), 32'h19);
        run(45);

        restart(16'h0050, 4'b0000, 1'b1); run(2 * F + 2);
        restart(16'h0050, 4'b0000, 1'b0); run(F + 2);
        restart(16'h00A0, 4'b0100, 1'b0); run(F + 2);

        // Mid-frame input change lands only at next frame
        restart(16'h1111, 4'b0000, 1'b0);
        run(7);
        digits = 16'h2222;
        run(2 * F);

        // Enable drop during digit 2's dwell, then re-enable
        restart(16'h5678, 4'b1010, 1'b0);
        run(13);
        enable = 1'b0;
        run(2);
        enable = 1'b1;
        run(F + 3);

        // Reset pulse mid-frame with enable held
        restart(16'h9081, 4'b0001, 1'b1);
        run(8);
        reset = 1'b1;
        run(1);
        reset = 1'b0;
        run(F + 5);

        // Randomized sessions
        for (int it = 0; it < 30; it++) begin
            logic [15:0] rd;
            for (int k = 0; k < 4; k++)
                rd[4*k +: 4] = ($urandom_range(1) == 0) ? 4'd0 : 4'($urandom_range(15));
            restart(rd, 4'($urandom_range(15)), 1'($urandom_range(1)));
            for (int c = 0, n = $urandom_range(60, 5); c < n; c++) begin
                if ($urandom_range(99) < 5) enable = ~enable;
                if ($urandom_range(99) < 3) reset = 1'b1; else reset = 1'b0;
                if ($urandom_range(99) < 5) blank_lz = ~blank_lz;
                if ($urandom_range(99) < 8) digits = 16'($urandom_range(65535));
                if ($urandom_range(99) < 8) dp_mask = 4'($urandom_range(15));
                step();
            end
            reset = 1'b0;
            enable = 1'b1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
